letc_core_pipe_fifo: RTL and testbench
======================================

Name: letc_core_pipe_fifo

Overview:
- Parametrised elastic buffer placed between LETC Core pipeline stages (f1->f2, f2->d, d->e1, e1->e2, e2->w).
- Carries one packed stage struct per entry, flattened to DATA_WIDTH bits.
- Provides valid/ready backpressure, synchronous flush for branch/trap redirect, optional zero-latency fall-through, and an occupancy count.
- Generalises the fixed single-register stage boundary to DEPTH entries.

Parameters:
- DATA_WIDTH, 64, payload width in bits; instantiators pass $bits(<stage struct>); must be >= 1.
- DEPTH, 2, number of storage entries; must be >= 1; need not be a power of two.
- FALLTHROUGH, 0, 1 = when empty, input appears on the output in the same cycle; 0 = minimum latency is 1 cycle.

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous flush: discard all entries and any input this cycle
- i_valid  input  1  upstream has a payload
- o_ready  output  1  buffer accepts a payload this cycle
- i_data  input  DATA_WIDTH  upstream payload
- o_valid  output  1  payload available downstream
- i_ready  input  1  downstream accepts a payload this cycle
- o_data  output  DATA_WIDTH  head payload
- o_count  output  $clog2(DEPTH+1)  entries currently stored, excluding a fall-through payload
- o_full  output  1  count == DEPTH
- o_empty  output  1  count == 0

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - Read/write pointers and count go to 0.
  - All storage entries go to 0.
  - o_valid = 0, o_ready = 1 (o_ready drops to 0 once count reaches DEPTH), o_count = 0, o_full = 0, o_empty = 1, o_data = 0.
  - Reset may assert mid-operation; all stored payloads are lost, with no partial-state retention.
- Handshake:
  - Push occurs when i_valid && o_ready; pop occurs when o_valid && i_ready.
  - o_ready = !o_full && !i_flush. o_ready is registered-state based with no combinational path from i_ready, so a full buffer does not accept even while being popped.
  - o_valid = !o_empty && !i_flush, or in FALLTHROUGH mode (o_empty && i_valid && !i_flush).
- Ordering: strict FIFO. o_data = entry[rd_ptr] when non-empty; when empty in FALLTHROUGH mode it is i_data.
- Latency:
  - FALLTHROUGH=0: a payload pushed in cycle N is visible on o_data/o_valid in cycle N+1.
  - FALLTHROUGH=1: when empty, the payload is visible in cycle N. If popped in cycle N it is never stored and count stays 0; if not popped it is written and count becomes 1.
- Pointers: wrap from DEPTH-1 to 0 explicitly (compare against DEPTH-1, not a power-of-two mask).
- Count update: push and pop in the same cycle (non-empty, non-full) leaves count unchanged, both pointers advance, and the entry write and head read are at different indices. Push only: count+1. Pop only: count-1.
- Flush (i_flush=1 in cycle N):
  - o_valid = 0 and o_ready = 0 in cycle N; no push or pop happens.
  - In cycle N+1, pointers and count = 0.
  - Flush has priority over every other event, including simultaneous push/pop.
  - Storage contents are not cleared by flush.
- DEPTH=1: full and empty are mutually exclusive single states; with FALLTHROUGH=0 throughput is one payload every 2 cycles under continuous traffic, which is an accepted limitation.
- Upstream protocol: a source holds i_data stable while i_valid && !o_ready. The buffer's own o_data is stable while o_valid && !i_ready, except on flush.
- Illegal parameters (DEPTH < 1 or DATA_WIDTH < 1) fail at elaboration via a static assertion.
- Simulation assertions: count never exceeds DEPTH; no pop when empty in FALLTHROUGH=0 mode.

Decomposition:
- letc_core_pkg gains no new typedefs; stage payloads use the existing f1_to_f2_s / f2_to_d_s / d_to_e1_s / e1_to_e2_s / e2_to_w_s structs.
- The struct valid bit is redundant with o_valid; instantiators pass the struct with valid tied high and regenerate it from o_valid.
- Pointer and count widths are local parameters.
- No sub-module: storage is a flat register array inside this module, with no memory macro.

Test Plan:
- Reset check, DEPTH=2, FALLTHROUGH=0: hold i_rst_n low, then release -> o_valid=0, o_ready=1, o_count=0, o_empty=1, o_data=0.
- Fill and drain, DEPTH=3, i_ready=0: push 0xA, 0xB, 0xC -> o_count=3, o_full=1, o_ready=0; a 4th push of 0xD is not accepted. Then i_ready=1 -> outputs 0xA, 0xB, 0xC on consecutive cycles, after which o_empty=1.
- Streaming, DEPTH=2, FALLTHROUGH=0, i_valid=i_ready=1 with data 1..100 -> first output one cycle after first push, one output per cycle thereafter, in order, with o_count steady at 1.
- Fall-through, DEPTH=2, FALLTHROUGH=1, empty buffer, i_valid=1, i_data=0x55, i_ready=1 -> o_valid=1 and o_data=0x55 in the same cycle; o_count stays 0.
- Flush with simultaneous traffic: count=2 (0x1, 0x2), assert i_flush with i_valid=1 (0x3) and i_ready=1 -> o_valid=0 and o_ready=0 that cycle; next cycle o_count=0, and 0x3 never appears on the output.
- Wrap and asynchronous reset, DEPTH=3: perform 7 push/pop pairs to cross the wrap point, with order preserved; then assert i_rst_n low mid-cycle with count=2 -> o_valid drops immediately and o_count=0.

Source files
------------

// File: rtl/letc_core_pipe_fifo_pkg.sv
// rtl/letc_core_pipe_fifo_pkg.sv - shared constants and width helpers for the LETC Core pipeline FIFO
//
// Purpose: sizing helpers used by letc_core_pipe_fifo so that every stage
//          boundary derives its pointer and count widths the same way.
// Contents:
//   FIFO_MIN_DEPTH / FIFO_MIN_WIDTH - smallest legal parameter values
//   fifo_ptr_width(depth)           - index width, never narrower than 1 bit
//   fifo_cnt_width(depth)           - width able to hold 0..depth inclusive

package letc_core_pipe_fifo_pkg;

    localparam int FIFO_MIN_DEPTH = 1;
    localparam int FIFO_MIN_WIDTH = 1;

    // A single-entry buffer still needs a 1-bit pointer to index storage.
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The count must reach DEPTH itself, hence depth+1 states.
    function automatic int fifo_cnt_width(input int depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

endpackage

// File: rtl/letc_core_pipe_fifo.sv
// rtl/letc_core_pipe_fifo.sv - parametrised elastic buffer between LETC Core pipeline stages
//
// Purpose: DEPTH-entry FIFO carrying one flattened stage struct per entry, with
//          valid/ready backpressure, synchronous flush for redirects and an
//          optional zero-latency fall-through when empty.
// Parameters:
//   DATA_WIDTH  - payload width in bits (>= 1)
//   DEPTH       - number of storage entries (>= 1, any value)
//   FALLTHROUGH - 1: empty buffer forwards i_data combinationally
// Ports:
//   i_clk, i_rst_n            - clock, asynchronous active-low reset
//   i_flush                   - discard contents and this cycle's input
//   i_valid, o_ready, i_data  - upstream handshake and payload
//   o_valid, i_ready, o_data  - downstream handshake and head payload
//   o_count, o_full, o_empty  - stored occupancy (fall-through payload excluded)

module letc_core_pipe_fifo
    import letc_core_pipe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_flush,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int PTR_W = fifo_ptr_width(DEPTH);
    localparam int CNT_W = fifo_cnt_width(DEPTH);
    localparam bit FT    = (FALLTHROUGH != 0);

    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < FIFO_MIN_DEPTH || DATA_WIDTH < FIFO_MIN_WIDTH) begin : g_bad_params
            $error("letc_core_pipe_fifo: DEPTH and DATA_WIDTH must both be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bypass;
    logic store;
    logic deq;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Ready depends only on registered state and flush, never on i_ready,
    // so a full buffer refuses input even in a cycle where it is popped.
    assign o_ready = !full && !i_flush;
    assign o_valid = (!empty || (FT && i_valid)) && !i_flush;
    assign o_data  = (FT && empty) ? i_data : mem[rd_ptr];

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    // Fall-through payload consumed in the same cycle never touches storage.
    assign bypass = FT && empty && pop;
    assign store  = push && !bypass;
    assign deq    = pop && !(FT && empty);

    assign o_count = count;
    assign o_full  = full;
    assign o_empty = empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({store, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (count <= DEPTH_CNT);
            if (!FT) begin
                assert (!(pop && empty));
            end
        end
    end

endmodule

// File: tb/tb_letc_core_pipe_fifo.sv
// tb/tb_letc_core_pipe_fifo.sv - directed self-checking bench for letc_core_pipe_fifo

module tb_letc_core_pipe_fifo;

    logic clk;
    logic rst_n;

    // DEPTH=2, FALLTHROUGH=0
    logic       a_flush, a_ivalid, a_oready, a_ovalid, a_iready, a_full, a_empty;
    logic [7:0] a_idata, a_odata;
    logic [1:0] a_count;

    // DEPTH=3, FALLTHROUGH=0
    logic       b_flush, b_ivalid, b_oready, b_ovalid, b_iready, b_full, b_empty;
    logic [7:0] b_idata, b_odata;
    logic [1:0] b_count;

    // DEPTH=2, FALLTHROUGH=1
    logic       c_flush, c_ivalid, c_oready, c_ovalid, c_iready, c_full, c_empty;
    logic [7:0] c_idata, c_odata;
    logic [1:0] c_count;

    int n_checks;
    int n_fail;

    letc_core_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(2), .FALLTHROUGH(0)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush),
        .i_valid(a_ivalid), .o_ready(a_oready), .i_data(a_idata),
        .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
        .o_count(a_count), .o_full(a_full), .o_empty(a_empty)
    );

    letc_core_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(3), .FALLTHROUGH(0)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush),
        .i_valid(b_ivalid), .o_ready(b_oready), .i_data(b_idata),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
        .o_count(b_count), .o_full(b_full), .o_empty(b_empty)
    );

    letc_core_pipe_fifo #(.DATA_WIDTH(8), .DEPTH(2), .FALLTHROUGH(1)) u_ft (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(c_flush),
        .i_valid(c_ivalid), .o_ready(c_oready), .i_data(c_idata),
        .o_valid(c_ovalid), .i_ready(c_iready), .o_data(c_odata),
        .o_count(c_count), .o_full(c_full), .o_empty(c_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {a_flush, a_ivalid, a_iready, a_idata} = '0;
        {b_flush, b_ivalid, b_iready, b_idata} = '0;
        {c_flush, c_ivalid, c_iready, c_idata} = '0;

        // Reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_valid", 64'(a_ovalid), 64'd0);
        check("rst_ready", 64'(a_oready), 64'd1);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_empty", 64'(a_empty), 64'd1);
        check("rst_full", 64'(a_full), 64'd0);
        check("rst_data", 64'(a_odata), 64'd0);

        // Fill and drain, DEPTH=3
        b_iready = 1'b0;
        b_ivalid = 1'b1;
        b_idata = 8'h0A; tick();
        b_idata = 8'h0B; tick();
        b_idata = 8'h0C; tick();
        b_idata = 8'h0D;
        #1;
        check("fill_count", 64'(b_count), 64'd3);
        check("fill_full", 64'(b_full), 64'd1);
        check("fill_ready", 64'(b_oready), 64'd0);
        check("fill_head", 64'(b_odata), 64'h0A);
        tick();
        b_ivalid = 1'b0;
        b_iready = 1'b1;
        #1;
        check("d4_rejected_count", 64'(b_count), 64'd3);
        check("drain0_valid", 64'(b_ovalid), 64'd1);
        check("drain0_data", 64'(b_odata), 64'h0A);
        tick(); #1;
        check("drain1_data", 64'(b_odata), 64'h0B);
        tick(); #1;
        check("drain2_data", 64'(b_odata), 64'h0C);
        check("drain2_count", 64'(b_count), 64'd1);
        tick(); #1;
        check("drain_empty", 64'(b_empty), 64'd1);
        check("drain_valid", 64'(b_ovalid), 64'd0);
        b_iready = 1'b0;

        // Streaming, DEPTH=2
        a_ivalid = 1'b1;
        a_iready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            a_idata = 8'(k + 1);
            #1;
            if (k == 0) begin
                check("stream_first_valid", 64'(a_ovalid), 64'd0);
            end else begin
                check("stream_valid", 64'(a_ovalid), 64'd1);
                check("stream_data", 64'(a_odata), 64'(k));
                check("stream_count", 64'(a_count), 64'd1);
            end
            tick();
        end
        a_ivalid = 1'b0;
        #1;
        check("stream_last_data", 64'(a_odata), 64'd100);
        check("stream_last_valid", 64'(a_ovalid), 64'd1);
        tick(); #1;
        check("stream_end_empty", 64'(a_empty), 64'd1);

        // Flush with simultaneous push and pop
        a_iready = 1'b0;
        a_ivalid = 1'b1;
        a_idata = 8'h01; tick();
        a_idata = 8'h02; tick();
        #1;
        check("pre_flush_count", 64'(a_count), 64'd2);
        a_flush  = 1'b1;
        a_idata  = 8'h03;
        a_iready = 1'b1;
        #1;
        check("flush_valid", 64'(a_ovalid), 64'd0);
        check("flush_ready", 64'(a_oready), 64'd0);
        tick();
        a_flush  = 1'b0;
        a_ivalid = 1'b0;
        #1;
        check("post_flush_count", 64'(a_count), 64'd0);
        check("post_flush_valid", 64'(a_ovalid), 64'd0);
        a_ivalid = 1'b1;
        a_iready = 1'b0;
        a_idata  = 8'h04;
        tick();
        a_ivalid = 1'b0;
        #1;
        check("post_flush_data", 64'(a_odata), 64'h04);
        check("post_flush_cnt1", 64'(a_count), 64'd1);

        // Wrap, DEPTH=3: one lead push, then 7 push/pop pairs
        b_ivalid = 1'b1;
        b_iready = 1'b0;
        b_idata  = 8'h10;
        tick();
        b_iready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            b_idata = 8'(8'h10 + k);
            #1;
            check("wrap_data", 64'(b_odata), 64'(8'h10 + k - 1));
            check("wrap_count", 64'(b_count), 64'd1);
            tick();
        end
        b_iready = 1'b0;
        b_idata  = 8'h18;
        tick();
        b_ivalid = 1'b0;
        #1;
        check("wrap_count2", 64'(b_count), 64'd2);
        check("wrap_head", 64'(b_odata), 64'h17);

        // Asynchronous reset mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(b_ovalid), 64'd0);
        check("areset_count", 64'(b_count), 64'd0);
        check("areset_data", 64'(b_odata), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fall-through, DEPTH=2
        c_ivalid = 1'b1;
        c_iready = 1'b1;
        c_idata  = 8'h55;
        #1;
        check("ft_valid", 64'(c_ovalid), 64'd1);
        check("ft_data", 64'(c_odata), 64'h55);
        check("ft_count", 64'(c_count), 64'd0);
        tick();
        c_idata  = 8'h66;
        c_iready = 1'b0;
        #1;
        check("ft_bypass_count", 64'(c_count), 64'd0);
        check("ft_hold_data", 64'(c_odata), 64'h66);
        tick();
        c_ivalid = 1'b0;
        #1;
        check("ft_stored_count", 64'(c_count), 64'd1);
        check("ft_stored_data", 64'(c_odata), 64'h66);
        check("ft_stored_valid", 64'(c_ovalid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
